// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_unit
//  Description : Registered, parametrised ALU with full flag set and
//                iterative (one bit per cycle) shift and multiply.
//                Valid/ready handshake on both input and output.
//  Ports       : clk, rst_n              - clock, async active-low reset
//                in_valid / in_ready     - operation handshake
//                data_1, data_2, sel     - operand A, operand B, opcode
//                out_valid / out_ready   - result handshake
//                alu_out                 - registered result
//                alu_*_flag              - zero, carry, negative, overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             alu_zero_flag,
    output logic             alu_carry_flag,
    output logic             alu_neg_flag,
    output logic             alu_ovf_flag
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_PASS = 4'd9;

    // WIDTH always fits in WIDTH bits (WIDTH >= 2), so the saturation test
    // can be done at operand width without any widening.
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [3:0]           op;
    logic [CNT_W-1:0]     cnt;
    // work: shift register for SHL/SHR, multiplier (consumed LSB first) for MUL
    logic [WIDTH-1:0]     work;
    logic                 shift_c;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   prod;

    logic [CNT_W-1:0]     start_cnt;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     res;
    logic                 res_c;
    logic                 res_v;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Number of iteration steps for the incoming op; zero for single-cycle ops.
    always_comb begin
        start_cnt = '0;
        if (sel == OP_SHL || sel == OP_SHR) begin
            start_cnt = (data_2 >= WIDTH_V) ? CNT_MAX : CNT_W'(data_2);
        end else if (sel == OP_MUL) begin
            start_cnt = CNT_MAX;
        end
    end

    // Final result and flags, evaluated from the latched operands once the
    // iteration count has run out.
    always_comb begin
        sum   = {1'b0, a_reg} + {1'b0, b_reg};
        diff  = {1'b0, a_reg} - {1'b0, b_reg};
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (sum[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                res_c = diff[WIDTH];  // borrow out of the extended subtract
                res_v = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                        (diff[WIDTH-1] != a_reg[WIDTH-1]);
            end
            OP_AND:  res = a_reg & b_reg;
            OP_OR:   res = a_reg | b_reg;
            OP_XOR:  res = a_reg ^ b_reg;
            OP_NOT:  res = ~a_reg;
            OP_SHL, OP_SHR: begin
                res   = work;
                res_c = shift_c;
            end
            OP_MUL: begin
                res   = prod[WIDTH-1:0];
                res_c = |prod[2*WIDTH-1:WIDTH];
            end
            OP_PASS: res = b_reg;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            op             <= '0;
            cnt            <= '0;
            work           <= '0;
            shift_c        <= 1'b0;
            mcand          <= '0;
            prod           <= '0;
            alu_out        <= '0;
            alu_zero_flag  <= 1'b0;
            alu_carry_flag <= 1'b0;
            alu_neg_flag   <= 1'b0;
            alu_ovf_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= data_1;
                        b_reg   <= data_2;
                        op      <= sel;
                        cnt     <= start_cnt;
                        work    <= (sel == OP_MUL) ? data_2 : data_1;
                        shift_c <= 1'b0;
                        mcand   <= {{WIDTH{1'b0}}, data_1};
                        prod    <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                        case (op)
                            OP_SHL: begin
                                shift_c <= work[WIDTH-1];
                                work    <= work << 1;
                            end
                            OP_SHR: begin
                                shift_c <= work[0];
                                work    <= work >> 1;
                            end
                            OP_MUL: begin
                                if (work[0]) begin
                                    prod <= prod + mcand;
                                end
                                mcand <= mcand << 1;
                                work  <= work >> 1;
                            end
                            default: ;
                        endcase
                    end else begin
                        alu_out        <= res;
                        alu_zero_flag  <= (res == '0);
                        alu_carry_flag <= res_c;
                        alu_neg_flag   <= res[WIDTH-1];
                        alu_ovf_flag   <= res_v;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_alu_seq_unit
//  Description : Self-checking bench for alu_seq_unit (WIDTH=8): directed
//                corner cases, random ops against an arithmetic model,
//                back-pressure, back-to-back and mid-operation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] data_1 = '0;
    logic [7:0] data_2 = '0;
    logic [3:0] sel = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] alu_out;
    logic       alu_zero_flag;
    logic       alu_carry_flag;
    logic       alu_neg_flag;
    logic       alu_ovf_flag;

    int checks = 0;
    int errors = 0;

    alu_seq_unit #(.WIDTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_1         (data_1),
        .data_2         (data_2),
        .sel            (sel),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_out        (alu_out),
        .alu_zero_flag  (alu_zero_flag),
        .alu_carry_flag (alu_carry_flag),
        .alu_neg_flag   (alu_neg_flag),
        .alu_ovf_flag   (alu_ovf_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       v;
        logic [7:0] lat;
    } exp_t;

    // Reference: plain integer arithmetic on the opcode definitions.
    // lat = clock edges from the accepting edge until out_valid is seen.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        exp_t e;
        int ai, bi, full, n, ri;
        ai = a; bi = b; ri = 0;
        e.c = 1'b0; e.v = 1'b0; e.lat = 8'd1;
        n = (bi < 8) ? bi : 8;
        case (s)
            4'd0: begin
                full = ai + bi; ri = full % 256; e.c = (full > 255);
                e.v = ((ai >= 128) == (bi >= 128)) && ((ri >= 128) != (ai >= 128));
            end
            4'd1: begin
                full = ai - bi; ri = (full + 256) % 256; e.c = (ai < bi);
                e.v = ((ai >= 128) != (bi >= 128)) && ((ri >= 128) != (ai >= 128));
            end
            4'd2: ri = ai & bi;
            4'd3: ri = ai | bi;
            4'd4: ri = ai ^ bi;
            4'd5: ri = 255 - ai;
            4'd6: begin
                ri = (ai << n) % 256;
                e.c = (n == 0) ? 1'b0 : 1'((ai >> (8 - n)) % 2);
                e.lat = 8'(n + 1);
            end
            4'd7: begin
                ri = ai >> n;
                e.c = (n == 0) ? 1'b0 : 1'((ai >> (n - 1)) % 2);
                e.lat = 8'(n + 1);
            end
            4'd8: begin
                full = ai * bi; ri = full % 256; e.c = (full > 255);
                e.lat = 8'd9;
            end
            4'd9: ri = bi;
            default: ri = 0;
        endcase
        e.r = 8'(ri);
        return e;
    endfunction

    // Drives one operation, waits (bounded) for the result, completes the
    // output handshake. lat = -1 when no result appears.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                          output logic [7:0] r, output logic z, output logic c,
                          output logic ng, output logic v, output int lat);
        @(negedge clk);
        data_1 = a; data_2 = b; sel = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        r = alu_out; z = alu_zero_flag; c = alu_carry_flag; ng = alu_neg_flag; v = alu_ovf_flag;
        if (lat > 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        checks++;
        if ({alu_out, alu_zero_flag, alu_carry_flag, alu_neg_flag, alu_ovf_flag} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: alu_out=%h z%b c%b n%b v%b, required all 0",
                     alu_out, alu_zero_flag, alu_carry_flag, alu_neg_flag, alu_ovf_flag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        exp_t tbl [14];
        logic [7:0] ta [14];
        logic [7:0] tb [14];
        logic [3:0] ts [14];
        logic [7:0] r;
        logic z, c, ng, v;
        int lat;
        // a, b, op, expected {result, carry, ovf, latency}
        ta = '{8'hFC, 8'hFC, 8'h7F, 8'h01, 8'h0F, 8'h10, 8'h81, 8'h81, 8'hFF, 8'h80, 8'h5A, 8'h77, 8'h11, 8'h80};
        tb = '{8'h01, 8'h04, 8'h01, 8'h02, 8'h11, 8'h10, 8'h01, 8'h00, 8'h09, 8'h08, 8'h00, 8'h3C, 8'h22, 8'h01};
        ts = '{4'd0,  4'd0,  4'd0,  4'd1,  4'd8,  4'd8,  4'd6,  4'd7,  4'd6,  4'd7,  4'd5,  4'd9,  4'd12, 4'd1};
        tbl = '{ '{8'hFD, 1'b0, 1'b0, 8'd1}, '{8'h00, 1'b1, 1'b0, 8'd1}, '{8'h80, 1'b0, 1'b1, 8'd1},
                 '{8'hFF, 1'b1, 1'b0, 8'd1}, '{8'hFF, 1'b0, 1'b0, 8'd9}, '{8'h00, 1'b1, 1'b0, 8'd9},
                 '{8'h02, 1'b1, 1'b0, 8'd2}, '{8'h81, 1'b0, 1'b0, 8'd1}, '{8'h00, 1'b1, 1'b0, 8'd9},
                 '{8'h00, 1'b1, 1'b0, 8'd9}, '{8'hA5, 1'b0, 1'b0, 8'd1}, '{8'h3C, 1'b0, 1'b0, 8'd1},
                 '{8'h00, 1'b0, 1'b0, 8'd1}, '{8'h7F, 1'b0, 1'b1, 8'd1} };
        for (int i = 0; i < 14; i++) begin
            run_op(ta[i], tb[i], ts[i], r, z, c, ng, v, lat);
            checks++;
            if (r !== tbl[i].r || c !== tbl[i].c || v !== tbl[i].v || z !== (tbl[i].r == 8'h00) ||
                ng !== tbl[i].r[7] || lat != int'(tbl[i].lat)) begin
                errors++;
                $display("FAIL directed_%0d: got r=%h c%b v%b z%b n%b lat=%0d, required r=%h c%b v%b z%b n%b lat=%0d",
                         i, r, c, v, z, ng, lat, tbl[i].r, tbl[i].c, tbl[i].v,
                         (tbl[i].r == 8'h00), tbl[i].r[7], tbl[i].lat);
            end
        end
    endtask

    // MUL with in_valid held high (and operands changing) while busy.
    task automatic test_mul_busy();
        int lat;
        logic busy_ok;
        @(negedge clk);
        data_1 = 8'h0F; data_2 = 8'h11; sel = 4'd8; in_valid = 1'b1;
        @(posedge clk); #1;
        data_1 = 8'hAA; data_2 = 8'h55; sel = 4'd0;
        lat = -1; busy_ok = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
            if (in_ready !== 1'b0) busy_ok = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (!busy_ok || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mul_in_ready: in_ready seen high during MUL, required 0");
        end
        checks++;
        if (lat != 9 || alu_out !== 8'hFF || alu_carry_flag !== 1'b0) begin
            errors++;
            $display("FAIL mul_busy_result: lat=%0d r=%h c%b, required lat=9 r=ff c0", lat, alu_out, alu_carry_flag);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mul_return_idle: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic held_ok;
        out_ready = 1'b0;
        @(negedge clk);
        data_1 = 8'hF0; data_2 = 8'h3C; sel = 4'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        held_ok = (lat == 1);
        for (int i = 0; i < 5; i++) begin
            data_1 = 8'($urandom_range(0, 255)); data_2 = 8'($urandom_range(0, 255));
            sel = 4'd0; in_valid = i[0];
            @(posedge clk); #1;
            if (alu_out !== 8'h30 || out_valid !== 1'b1 || in_ready !== 1'b0 || alu_zero_flag !== 1'b0)
                held_ok = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (!held_ok) begin
            errors++;
            $display("FAIL backpressure_hold: r=%h out_valid=%b in_ready=%b lat=%0d, required r=30 1/0 lat=1",
                     alu_out, out_valid, in_ready, lat);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_out !== 8'h30) begin
            errors++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b r=%h, required 0/1 r=30",
                     out_valid, in_ready, alu_out);
        end
    endtask

    // in_valid held high across a stream of ops; results checked in order.
    task automatic test_back_to_back();
        logic [7:0] qa [8];
        logic [7:0] qb [8];
        logic [3:0] qs [8];
        exp_t e;
        int acc_i, chk_i, cyc;
        logic ir, ov, accepted, seq_ok;
        for (int i = 0; i < 8; i++) begin
            qa[i] = 8'($urandom_range(0, 255));
            qb[i] = 8'($urandom_range(0, 10));
            qs[i] = 4'($urandom_range(0, 9));
        end
        acc_i = 0; chk_i = 0; cyc = 0; seq_ok = 1'b1;
        while (chk_i < 8 && cyc < 300) begin
            @(negedge clk);
            ir = in_ready; ov = out_valid;
            if (ov) begin
                e = model(qa[chk_i], qb[chk_i], qs[chk_i]);
                if (alu_out !== e.r || alu_carry_flag !== e.c || alu_ovf_flag !== e.v) begin
                    seq_ok = 1'b0;
                    $display("FAIL back_to_back_%0d: r=%h c%b v%b, required r=%h c%b v%b",
                             chk_i, alu_out, alu_carry_flag, alu_ovf_flag, e.r, e.c, e.v);
                end
                chk_i++;
            end
            if (acc_i < 8) begin
                in_valid = 1'b1; data_1 = qa[acc_i]; data_2 = qb[acc_i]; sel = qs[acc_i];
            end else begin
                in_valid = 1'b0;
            end
            accepted = in_valid && ir;
            @(posedge clk);
            if (accepted) acc_i++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (!seq_ok || chk_i != 8) begin
            errors++;
            $display("FAIL back_to_back: results=%0d of 8, required 8 matching", chk_i);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random(input int n);
        exp_t e;
        logic [7:0] a, b, r;
        logic [3:0] s;
        logic z, c, ng, v;
        int lat;
        for (int i = 0; i < n; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            s = 4'($urandom_range(0, 15));
            if ((s == 4'd6 || s == 4'd7) && $urandom_range(0, 3) != 0) b = 8'($urandom_range(0, 9));
            e = model(a, b, s);
            run_op(a, b, s, r, z, c, ng, v, lat);
            checks++;
            if (r !== e.r || c !== e.c || v !== e.v || z !== (e.r == 8'h00) ||
                ng !== e.r[7] || lat != int'(e.lat)) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got r=%h c%b v%b z%b n%b lat=%0d, required r=%h c%b v%b lat=%0d",
                         i, s, a, b, r, c, v, z, ng, lat, e.r, e.c, e.v, e.lat);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [7:0] r;
        logic z, c, ng, v, seen;
        int lat;
        run_op(8'h55, 8'h22, 4'd0, r, z, c, ng, v, lat);  // leaves alu_out = 0x77
        @(negedge clk);
        data_1 = 8'h0F; data_2 = 8'h11; sel = 4'd8; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({alu_out, alu_zero_flag, alu_carry_flag, alu_neg_flag, alu_ovf_flag, out_valid} !== 13'h0 ||
            in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_mul: r=%h out_valid=%b in_ready=%b, required r=00 0/1",
                     alu_out, out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_result: out_valid seen=%b after reset, required 0", seen);
        end
        run_op(8'h12, 8'h34, 4'd0, r, z, c, ng, v, lat);
        checks++;
        if (r !== 8'h46 || c !== 1'b0 || z !== 1'b0 || lat != 1) begin
            errors++;
            $display("FAIL add_after_reset: r=%h c%b z%b lat=%0d, required r=46 c0 z0 lat=1", r, c, z, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul_busy();
        test_backpressure();
        test_back_to_back();
        test_random(150);
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
